// File: rtl/hex_scan_display_pkg.sv
// Shared constants for the multiplexed hex display:
// PicoBlaze port map, control bits and segment glyphs.
package hex_scan_display_pkg;

    localparam logic [7:0] PORT_LO_DEF   = 8'h02;
    localparam logic [7:0] PORT_HI_DEF   = 8'h03;
    localparam logic [7:0] PORT_CTRL_DEF = 8'h06;

    localparam int CTRL_BLANK = 0;
    localparam int CTRL_LZ    = 1;

    localparam logic [6:0] SEG_OFF = 7'b1111111;

    // Active-low glyphs, bit 6 = segment a ... bit 0 = segment g.
    localparam logic [15:0][6:0] SEG_LUT = {
        7'b0111000, // F
        7'b0110000, // E
        7'b1000010, // d
        7'b0110001, // C
        7'b1100000, // b
        7'b0001000, // A
        7'b0000100, // 9
        7'b0000000, // 8
        7'b0001111, // 7
        7'b0100000, // 6
        7'b0100100, // 5
        7'b1001100, // 4
        7'b0000110, // 3
        7'b0010010, // 2
        7'b1001111, // 1
        7'b0000001  // 0
    };

endpackage

// File: rtl/hex_scan_display_decode.sv
// Nibble to active-low 7-segment pattern, seg[0] = a.
module hex7seg_decode
    import hex_scan_display_pkg::*;
(
    input  logic [3:0] nib,
    output logic [0:6] seg
);

    assign seg = SEG_LUT[nib];

endmodule

// File: rtl/hex_scan_display.sv
// Four-digit multiplexed hex display behind PicoBlaze output ports,
// with atomic 16-bit commit, blanking and leading-zero suppression.
module hex_scan_display
    import hex_scan_display_pkg::*;
#(
    parameter int         SCAN_DIV  = 100000,
    parameter int         BLANK_CYC = 16,
    parameter logic [7:0] PORT_LO   = PORT_LO_DEF,
    parameter logic [7:0] PORT_HI   = PORT_HI_DEF,
    parameter logic [7:0] PORT_CTRL = PORT_CTRL_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] port_id,
    input  logic       write_strobe,
    input  logic [7:0] out_port,
    output logic [0:6] seg,
    output logic [3:0] an,
    output logic       busy_commit
);

    localparam int CW = $clog2(SCAN_DIV);

    logic [7:0]    shadow_lo;
    logic [15:0]   disp;
    logic [1:0]    ctrl;
    logic [CW-1:0] cnt;
    logic [1:0]    idx;

    logic          hit_lo;
    logic          hit_hi;
    logic          hit_ctrl;
    logic          slot_end;
    logic          in_blank;
    logic [3:0]    nib;
    logic [0:6]    glyph;
    logic          suppress;
    logic [3:0]    an_next;
    logic [0:6]    seg_next;

    assign hit_lo   = write_strobe && (port_id == PORT_LO);
    assign hit_hi   = write_strobe && (port_id == PORT_HI);
    assign hit_ctrl = write_strobe && (port_id == PORT_CTRL);

    assign slot_end = (cnt == CW'(SCAN_DIV - 1));
    assign in_blank = (cnt < CW'(BLANK_CYC));

    always_comb begin
        nib = disp[3:0];
        unique case (idx)
            2'd0: nib = disp[3:0];
            2'd1: nib = disp[7:4];
            2'd2: nib = disp[11:8];
            2'd3: nib = disp[15:12];
            default: nib = disp[3:0];
        endcase
    end

    hex7seg_decode u_dec (
        .nib (nib),
        .seg (glyph)
    );

    // A digit goes dark when it and every digit left of it are zero.
    always_comb begin
        suppress = 1'b0;
        if (ctrl[CTRL_LZ]) begin
            unique case (idx)
                2'd3: suppress = (disp[15:12] == 4'h0);
                2'd2: suppress = (disp[15:8] == 8'h00);
                2'd1: suppress = (disp[15:4] == 12'h000);
                default: suppress = 1'b0;
            endcase
        end
    end

    always_comb begin
        an_next  = 4'b1111;
        seg_next = glyph;
        if (ctrl[CTRL_BLANK]) begin
            seg_next = SEG_OFF;
        end else begin
            if (!in_blank) begin
                an_next[idx] = 1'b0;
            end
            if (suppress) begin
                seg_next = SEG_OFF;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shadow_lo   <= 8'h00;
            disp        <= 16'h0000;
            ctrl        <= 2'b00;
            cnt         <= '0;
            idx         <= 2'd0;
            busy_commit <= 1'b0;
            an          <= 4'b1111;
            seg         <= SEG_OFF;
        end else begin
            busy_commit <= hit_hi;
            unique case (1'b1)
                hit_lo:   shadow_lo <= out_port;
                hit_hi:   disp      <= {out_port, shadow_lo};
                hit_ctrl: ctrl      <= out_port[1:0];
                default:  ;
            endcase
            if (slot_end) begin
                cnt <= '0;
                idx <= idx + 2'd1;
            end else begin
                cnt <= cnt + CW'(1);
            end
            an  <= an_next;
            seg <= seg_next;
        end
    end

endmodule

// File: tb/tb_hex_scan_display.sv
// Randomised scoreboard bench for hex_scan_display against a
// cycle-indexed behavioural model of the display.
module tb_hex_scan_display;

    localparam int SD = 8;
    localparam int BC = 2;

    logic       clk;
    logic       rst;
    logic [7:0] port_id;
    logic       write_strobe;
    logic [7:0] out_port;
    logic [0:6] seg;
    logic [3:0] an;
    logic       busy_commit;

    hex_scan_display #(
        .SCAN_DIV  (SD),
        .BLANK_CYC (BC),
        .PORT_LO   (8'h02),
        .PORT_HI   (8'h03),
        .PORT_CTRL (8'h06)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .port_id      (port_id),
        .write_strobe (write_strobe),
        .out_port     (out_port),
        .seg          (seg),
        .an           (an),
        .busy_commit  (busy_commit)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       busy;
    } exp_t;

    exp_t sbq[$];

    int checks = 0;
    int passes = 0;

    logic [6:0] glyph [16];

    logic [15:0] m_disp;
    logic [7:0]  m_lo;
    logic [1:0]  m_ctrl;
    int          n;

    initial begin
        glyph[0]  = 7'b0000001;
        glyph[1]  = 7'b1001111;
        glyph[2]  = 7'b0010010;
        glyph[3]  = 7'b0000110;
        glyph[4]  = 7'b1001100;
        glyph[5]  = 7'b0100100;
        glyph[6]  = 7'b0100000;
        glyph[7]  = 7'b0001111;
        glyph[8]  = 7'b0000000;
        glyph[9]  = 7'b0000100;
        glyph[10] = 7'b0001000;
        glyph[11] = 7'b1100000;
        glyph[12] = 7'b0110001;
        glyph[13] = 7'b1000010;
        glyph[14] = 7'b0110000;
        glyph[15] = 7'b0111000;
    end

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act == req) passes++;
        else $display("FAIL %s: got %0h expected %0h at %0t",
                      name, act, req, $time);
    endtask

    // Predictor: the n-th edge after reset release is at slot position
    // n mod SD of digit (n / SD) mod 4.
    always @(posedge clk) begin
        exp_t e;
        int k;
        int pos;
        logic [3:0] one;
        one = 4'b0001;
        if (!rst) begin
            e.an   = 4'b1111;
            e.seg  = 7'b1111111;
            e.busy = 1'b0;
            m_disp = 16'h0;
            m_lo   = 8'h0;
            m_ctrl = 2'b0;
            n      = 0;
        end else begin
            k   = (n / SD) % 4;
            pos = n % SD;
            e.busy = write_strobe && (port_id == 8'h03);
            if (m_ctrl[0]) begin
                e.an  = 4'b1111;
                e.seg = 7'b1111111;
            end else begin
                e.an = (pos < BC) ? 4'b1111 : ~(one << k);
                if (k > 0 && m_ctrl[1] && (m_disp >> (4 * k)) == 0)
                    e.seg = 7'b1111111;
                else
                    e.seg = glyph[(m_disp >> (4 * k)) & 16'hf];
            end
            if (write_strobe) begin
                if (port_id == 8'h02) m_lo = out_port;
                else if (port_id == 8'h03) m_disp = {out_port, m_lo};
                else if (port_id == 8'h06) m_ctrl = out_port[1:0];
            end
            n++;
        end
        sbq.push_back(e);
    end

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (sbq.size() == 0) begin
            chk("queue_empty", 0, 1);
        end else begin
            e = sbq.pop_front();
            chk("an", int'(an), int'(e.an));
            chk("seg", int'(seg), int'(e.seg));
            chk("busy_commit", int'(busy_commit), int'(e.busy));
        end
    end

    task automatic wr(input logic [7:0] p, input logic [7:0] d,
                      input logic s);
        @(negedge clk);
        port_id      = p;
        out_port     = d;
        write_strobe = s;
    endtask

    task automatic idle(input int cyc);
        repeat (cyc) begin
            @(negedge clk);
            write_strobe = 1'b0;
        end
    endtask

    task automatic async_reset_check();
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        chk("async_an", int'(an), 4'hf);
        chk("async_seg", int'(seg), 7'h7f);
        chk("async_busy", int'(busy_commit), 0);
        idle(2);
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        int p;
        rst          = 1'b0;
        port_id      = 8'h00;
        out_port     = 8'h00;
        write_strobe = 1'b0;
        idle(3);
        rst = 1'b1;
        idle(40);

        wr(8'h02, 8'h34, 1'b1);
        wr(8'h03, 8'h12, 1'b1);
        idle(40);

        wr(8'h02, 8'hAA, 1'b1);
        idle(12);
        wr(8'h03, 8'h00, 1'b1);
        idle(40);

        wr(8'h02, 8'h05, 1'b1);
        wr(8'h03, 8'h00, 1'b1);
        wr(8'h06, 8'h02, 1'b1);
        idle(40);
        wr(8'h02, 8'h00, 1'b1);
        wr(8'h03, 8'h00, 1'b1);
        idle(40);

        wr(8'h06, 8'h01, 1'b1);
        idle(40);
        wr(8'h06, 8'h00, 1'b1);
        idle(40);

        wr(8'h02, 8'h9C, 1'b1);
        wr(8'h03, 8'hE7, 1'b1);
        idle(5);
        wr(8'h07, 8'h11, 1'b1);
        wr(8'h82, 8'h22, 1'b1);
        wr(8'h03, 8'h33, 1'b0);
        wr(8'h86, 8'hFF, 1'b1);
        idle(40);

        async_reset_check();
        idle(20);

        for (int i = 0; i < 400; i++) begin
            p = int'($urandom_range(0, 9));
            unique case (p)
                0, 1, 2: wr(8'h02, 8'($urandom), 1'b1);
                3, 4, 5: wr(8'h03, 8'($urandom_range(0, 3) == 0 ?
                                       0 : $urandom), 1'b1);
                6: wr(8'h06, 8'($urandom_range(0, 3) == 0 ?
                                $urandom : ($urandom & 32'hfe)), 1'b1);
                7: wr(8'($urandom), 8'($urandom), 1'b1);
                8: wr(8'h03, 8'($urandom), 1'b0);
                default: idle(int'($urandom_range(1, 6)));
            endcase
        end

        wr(8'h02, 8'h77, 1'b1);
        wr(8'h03, 8'h66, 1'b1);
        idle(10);
        wr(8'h02, 8'h55, 1'b1);
        #2;
        rst = 1'b0;
        idle(3);
        rst = 1'b1;
        wr(8'h03, 8'h00, 1'b0);
        idle(40);

        for (int w = 0; w < 10 && sbq.size() > 0; w++) @(posedge clk);
        #2;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
